// File: rtl/timer_ctrl_if.sv
// AXI4-Lite configuration bundle for timer_ctrl. The master drives requests and the slave drives responses.
interface timer_ctrl_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/timer_ctrl.sv
// Prescaled 32-bit compare timer with an AXI4-Lite register file (CTRL/CMP/VAL/STATUS)
// and a registered level interrupt.
module timer_ctrl #(
    parameter logic [31:0] RESET_CMP = 32'hFFFF_FFFF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    timer_ctrl_if.slave  cfg,
    output logic         intr_o
);

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_CMP    = 8'h04;
    localparam logic [7:0] ADDR_VAL    = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h0C;

    logic        ctrl_en, ctrl_irq_en, ctrl_periodic;
    logic [7:0]  ctrl_prescale;
    logic [31:0] cmp_q, val_q;
    logic        match_q;
    logic [7:0]  presc_q;

    logic        aw_held, w_held;
    logic [7:0]  awaddr_q;
    logic [31:0] wdata_q;
    logic        bvalid_q, rvalid_q;
    logic [31:0] rdata_q;

    logic        aw_fire, w_fire, wr_do, ar_fire;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data, rd_mux;
    logic        wr_ctrl, wr_cmp, wr_val, wr_status;
    logic        tick, match_evt;

    // Byte strobes and upper address bits have no effect on this register file.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{cfg.wstrb, cfg.awaddr[31:8], cfg.araddr[31:8]};

    // Readies are held low during reset. A pending read blocks new writes.
    assign cfg.awready = rst_i & ~bvalid_q & ~cfg.arvalid & ~aw_held;
    assign cfg.wready  = rst_i & ~bvalid_q & ~cfg.arvalid & ~w_held;
    assign cfg.arready = rst_i & ~rvalid_q;
    assign cfg.bvalid  = bvalid_q;
    assign cfg.bresp   = 2'b00;
    assign cfg.rvalid  = rvalid_q;
    assign cfg.rdata   = rdata_q;
    assign cfg.rresp   = 2'b00;

    assign aw_fire = cfg.awvalid & cfg.awready;
    assign w_fire  = cfg.wvalid & cfg.wready;
    assign ar_fire = cfg.arvalid & cfg.arready;

    // The write commits when the second of AW and W is accepted. A held channel supplies its captured value.
    assign wr_do   = (aw_fire | aw_held) & (w_fire | w_held);
    assign wr_addr = aw_held ? awaddr_q : cfg.awaddr[7:0];
    assign wr_data = w_held ? wdata_q : cfg.wdata;

    assign wr_ctrl   = wr_do & (wr_addr == ADDR_CTRL);
    assign wr_cmp    = wr_do & (wr_addr == ADDR_CMP);
    assign wr_val    = wr_do & (wr_addr == ADDR_VAL);
    assign wr_status = wr_do & (wr_addr == ADDR_STATUS);

    assign tick      = ctrl_en & (presc_q == ctrl_prescale);
    assign match_evt = tick & ~wr_val & (val_q == cmp_q);

    always_comb begin
        // NOTE: default first so every path assigns rd_mux and no latch is inferred.
        rd_mux = '0;
        case (cfg.araddr[7:0])
            ADDR_CTRL:   rd_mux = {16'h0, ctrl_prescale, 5'h0, ctrl_periodic, ctrl_irq_en, ctrl_en};
            ADDR_CMP:    rd_mux = cmp_q;
            ADDR_VAL:    rd_mux = val_q;
            ADDR_STATUS: rd_mux = {31'h0, match_q};
            default:     rd_mux = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so that all updates on the same edge see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (wr_do) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_held  <= 1'b1;
                    awaddr_q <= cfg.awaddr[7:0];
                end
                if (w_fire) begin
                    w_held  <= 1'b1;
                    wdata_q <= cfg.wdata;
                end
            end

            if (wr_do)
                bvalid_q <= 1'b1;
            else if (cfg.bready)
                bvalid_q <= 1'b0;

            if (ar_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (cfg.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_en       <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            ctrl_periodic <= 1'b0;
            ctrl_prescale <= '0;
            cmp_q         <= RESET_CMP;
            val_q         <= '0;
            match_q       <= 1'b0;
            presc_q       <= '0;
            intr_o        <= 1'b0;
        end else begin
            // A CTRL write wins over a one-shot EN clear on the same edge.
            if (wr_ctrl) begin
                ctrl_en       <= wr_data[0];
                ctrl_irq_en   <= wr_data[1];
                ctrl_periodic <= wr_data[2];
                ctrl_prescale <= wr_data[15:8];
            end else if (match_evt && !ctrl_periodic) begin
                ctrl_en <= 1'b0;
            end

            if (wr_cmp)
                cmp_q <= wr_data;

            // A VAL write overrides the tick and restarts the prescaler.
            if (wr_val) begin
                val_q <= wr_data;
            end else if (tick) begin
                if (val_q == cmp_q) begin
                    if (ctrl_periodic)
                        val_q <= '0;
                end else begin
                    val_q <= val_q + 32'd1;
                end
            end

            if (wr_val || !ctrl_en || tick)
                presc_q <= '0;
            else
                presc_q <= presc_q + 8'd1;

            if (match_evt)
                match_q <= 1'b1;
            else if (wr_status && wr_data[0])
                match_q <= 1'b0;

            intr_o <= match_q & ctrl_irq_en;
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl. It drives the register bus through small tasks and checks each expected value with an immediate assertion.
module tb_timer_ctrl;
    logic clk_i;
    logic rst_i;
    logic intr_o;
    int   n_total = 0;
    int   n_pass  = 0;
    logic [31:0] rd;

    timer_ctrl_if bus ();

    timer_ctrl #(.RESET_CMP(32'hFFFF_FFFF)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cfg    (bus),
        .intr_o (intr_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic timeout(input string tag);
        n_total++;
        $error("FAIL %s: handshake timed out", tag);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
        bit aw_done = 0;
        bit w_done  = 0;
        bit b_done  = 0;
        int n = 0;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge clk_i);
            if (bus.awvalid && bus.awready) aw_done = 1;
            if (bus.wvalid && bus.wready)   w_done  = 1;
            step();
            if (aw_done) bus.awvalid = 1'b0;
            if (w_done)  bus.wvalid  = 1'b0;
            n++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        while (!b_done && n < 40) begin
            @(negedge clk_i);
            if (bus.bvalid) b_done = 1;
            step();
            n++;
        end
        bus.bready = 1'b0;
        if (!b_done) timeout("write");
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        bit a_done = 0;
        bit r_done = 0;
        int n = 0;
        data        = '0;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!a_done && n < 20) begin
            @(negedge clk_i);
            if (bus.arready) a_done = 1;
            step();
            n++;
        end
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        while (!r_done && n < 40) begin
            @(negedge clk_i);
            if (bus.rvalid) begin
                r_done = 1;
                data   = bus.rdata;
            end
            step();
            n++;
        end
        bus.rready = 1'b0;
        if (!r_done) timeout("read");
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check(tag, d, exp);
    endtask

    initial begin
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0;
        bus.wstrb   = 4'hF; bus.bready = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0;
        bus.rready  = 1'b0;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        step();

        // Reset state
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_intr", intr_o, 0);
        check("idle_arready", bus.arready, 1);
        read_check("rst_ctrl", 32'h00, 32'h0);
        read_check("rst_cmp", 32'h04, 32'hFFFF_FFFF);
        read_check("rst_val", 32'h08, 32'h0);
        read_check("rst_status", 32'h0C, 32'h0);
        axi_write(32'h20, 32'hDEAD_BEEF);
        read_check("unmapped_read", 32'h20, 32'h0);

        // Periodic, PRESCALE 0, CMP 3
        axi_write(32'h04, 32'd3);
        axi_write(32'h00, 32'h7);
        check("p_val1", dut.val_q, 1); check("p_match1", dut.match_q, 0); step();
        check("p_val2", dut.val_q, 2); step();
        check("p_val3", dut.val_q, 3); check("p_match3", dut.match_q, 0); step();
        check("p_val0", dut.val_q, 0); check("p_match4", dut.match_q, 1);
        check("p_intr_lag", intr_o, 0); step();
        check("p_intr_hi", intr_o, 1);
        axi_write(32'h00, 32'h0);
        axi_write(32'h0C, 32'h1);
        check("p_intr_cleared", intr_o, 0);
        axi_write(32'h08, 32'h0);

        // One-shot, PRESCALE 1, CMP 2
        axi_write(32'h04, 32'd2);
        axi_write(32'h00, 32'h103);
        check("o_val_e1", dut.val_q, 0); step();
        check("o_val_e2", dut.val_q, 1); step();
        check("o_val_e3", dut.val_q, 1); step();
        check("o_val_e4", dut.val_q, 2); step();
        check("o_match_e5", dut.match_q, 0); step();
        check("o_match_e6", dut.match_q, 1);
        repeat (6) step();
        read_check("o_val_stop", 32'h08, 32'd2);
        read_check("o_ctrl", 32'h00, 32'h102);
        read_check("o_status", 32'h0C, 32'h1);
        check("o_intr", intr_o, 1);
        axi_write(32'h0C, 32'h1);
        check("o_intr_clr", intr_o, 0);

        // W two cycles ahead of AW
        check("w_ready_idle", bus.wready, 1);
        bus.wdata = 32'h55; bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0; bus.wdata = 32'hAA;
        check("w_held_wready", bus.wready, 0);
        step();
        check("w_no_early_b", bus.bvalid, 0);
        bus.awaddr = 32'h08; bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        check("w_bvalid", bus.bvalid, 1);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("w_bvalid_clr", bus.bvalid, 0);
        read_check("w_val", 32'h08, 32'h55);

        // STATUS clear colliding with a match
        axi_write(32'h08, 32'h0);
        axi_write(32'h04, 32'd3);
        axi_write(32'h00, 32'h7);
        repeat (6) step();
        check("c_intr_before", intr_o, 1);
        bus.awaddr = 32'h0C; bus.wdata = 32'h1; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("c_bvalid", bus.bvalid, 1);
        check("c_match_kept", dut.match_q, 1);
        check("c_intr_kept", intr_o, 1);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("c_intr_next", intr_o, 1);
        axi_write(32'h00, 32'h2);
        read_check("c_status", 32'h0C, 32'h1);
        bus.awaddr = 32'h0C; bus.wdata = 32'h1; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("c_intr_same", intr_o, 1);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("c_intr_low", intr_o, 0);

        // 32-bit wrap without match
        axi_write(32'h08, 32'hFFFF_FFFF);
        axi_write(32'h04, 32'd5);
        axi_write(32'h00, 32'h1);
        check("wrap_val", dut.val_q, 0);
        check("wrap_nomatch", dut.match_q, 0);
        repeat (10) step();
        read_check("wrap_status", 32'h0C, 32'h1);
        read_check("wrap_val5", 32'h08, 32'd5);
        read_check("wrap_ctrl", 32'h00, 32'h0);

        // Reset during a running count with a read pending
        axi_write(32'h04, 32'd2);
        axi_write(32'h08, 32'h0);
        axi_write(32'h00, 32'h7);
        repeat (5) step();
        bus.araddr = 32'h00; bus.arvalid = 1'b1;
        step();
        bus.arvalid = 1'b0;
        check("r_rvalid_pend", bus.rvalid, 1);
        check("r_rdata_pend", bus.rdata, 32'h7);
        check("r_intr_pend", intr_o, 1);
        #2 rst_i = 1'b0;
        #1;
        check("r_ready_lo", {bus.awready, bus.wready, bus.arready}, 3'b000);
        check("r_valid_lo", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}, 6'b0);
        check("r_rdata_lo", bus.rdata, 0);
        check("r_intr_lo", intr_o, 0);
        step();
        rst_i = 1'b1;
        step();
        read_check("r_cmp", 32'h04, 32'hFFFF_FFFF);
        read_check("r_ctrl", 32'h00, 32'h0);
        read_check("r_val", 32'h08, 32'h0);
        read_check("r_status", 32'h0C, 32'h0);
        axi_write(32'h04, 32'h1234);
        read_check("r_cmp_wr", 32'h04, 32'h1234);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
